input_debouncer: RTL and testbench

// - Front-end conditioning stage for board-level switch/button inputs; feeds the three-input combiner.
// - Per channel: synchronise raw asynchronous input into clk domain, reject bounce/glitches,

---
 rtl/input_debouncer_pkg.sv | 18 +
 rtl/debounce_channel.sv | 131 +++++++++++++
 rtl/input_debouncer.sv | 36 +++
 tb/tb_input_debouncer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared types and default timing constants for the input debouncer slice.
package input_debouncer_pkg;

   // Per-channel debounce FSM encoding
   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHK_HI    = 2'd1,
      STABLE_HI = 2'd2,
      CHK_LO    = 2'd3
   } deb_state_t;

   // Default timing: ~1 ms of stability at 50 MHz
   localparam int DEF_NUM_CH        = 3;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 50000;
   localparam int DEF_CNT_WIDTH     = 16;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: synchroniser chain, stability counter and level FSM.
// clean flips only after the synchronised input has disagreed with it for
// STABLE_CYCLES consecutive samples; any agreeing sample aborts the candidate.
module debounce_channel
   import input_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall,
   output logic busy
);

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);
   localparam bit                   SINGLE_SAMPLE = (STABLE_CYCLES == 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_s;
   deb_state_t             state_r;
   logic [CNT_WIDTH-1:0]   cnt_r;
   logic                   clean_r;
   logic                   rise_r;
   logic                   fall_r;
   logic                   busy_r;

   // Metastability synchroniser: raw enters at bit 0, only the last stage is used
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      end
   end

   assign sync_s = sync_r[SYNC_STAGES-1];

   // Debounce FSM with registered level, strobes and busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= STABLE_LO;
         cnt_r   <= CNT_ZERO;
         clean_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
         case (state_r)
            STABLE_LO: begin
               if (sync_s) begin
                  if (SINGLE_SAMPLE) begin
                     state_r <= STABLE_HI;
                     clean_r <= 1'b1;
                     rise_r  <= 1'b1;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= CHK_HI;
                     cnt_r   <= CNT_ONE;
                     busy_r  <= 1'b1;
                  end
               end
            end
            CHK_HI: begin
               if (!sync_s) begin
                  state_r <= STABLE_LO;
                  cnt_r   <= CNT_ZERO;
                  busy_r  <= 1'b0;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= STABLE_HI;
                  cnt_r   <= CNT_ZERO;
                  clean_r <= 1'b1;
                  rise_r  <= 1'b1;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            STABLE_HI: begin
               if (!sync_s) begin
                  if (SINGLE_SAMPLE) begin
                     state_r <= STABLE_LO;
                     clean_r <= 1'b0;
                     fall_r  <= 1'b1;
                     busy_r  <= 1'b0;
                  end else begin
                     state_r <= CHK_LO;
                     cnt_r   <= CNT_ONE;
                     busy_r  <= 1'b1;
                  end
               end
            end
            CHK_LO: begin
               if (sync_s) begin
                  state_r <= STABLE_HI;
                  cnt_r   <= CNT_ZERO;
                  busy_r  <= 1'b0;
               end else if (cnt_r == CNT_LAST) begin
                  state_r <= STABLE_LO;
                  cnt_r   <= CNT_ZERO;
                  clean_r <= 1'b0;
                  fall_r  <= 1'b1;
                  busy_r  <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_r <= STABLE_LO;
               cnt_r   <= CNT_ZERO;
               clean_r <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign clean = clean_r;
   assign rise  = rise_r;
   assign fall  = fall_r;
   assign busy  = busy_r;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel switch/button conditioner: NUM_CH independent debounce channels
// whose clean levels feed the three-input combiner.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int NUM_CH        = DEF_NUM_CH,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] raw_in,
   output logic [NUM_CH-1:0] clean_out,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic [NUM_CH-1:0] busy
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      debounce_channel #(
         .SYNC_STAGES   (SYNC_STAGES),
         .STABLE_CYCLES (STABLE_CYCLES),
         .CNT_WIDTH     (CNT_WIDTH)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_in[g]),
         .clean (clean_out[g]),
         .rise  (rise_pulse[g]),
         .fall  (fall_pulse[g]),
         .busy  (busy[g])
      );
   end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with a per-cycle reference scoreboard.
module tb_input_debouncer;

   localparam int NCH    = 3;
   localparam int STABLE = 4;

   logic           clk;
   logic           rst;
   logic [NCH-1:0] raw_in;
   logic [NCH-1:0] clean_out;
   logic [NCH-1:0] rise_pulse;
   logic [NCH-1:0] fall_pulse;
   logic [NCH-1:0] busy;

   input_debouncer #(
      .NUM_CH        (NCH),
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (STABLE),
      .CNT_WIDTH     (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in),
      .clean_out  (clean_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NCH-1:0] clean;
      logic [NCH-1:0] rise;
      logic [NCH-1:0] fall;
      logic [NCH-1:0] busy;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int errors = 0;

   // reference model: two-flop delay plus "consecutive disagreement" counter
   logic [NCH-1:0] m_s1, m_sync, m_clean, m_rise, m_fall, m_busy;
   int             m_dis [NCH];
   int             n_rise [NCH];
   int             n_fall [NCH];

   task automatic check(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      exp_t e;
      m_rise = 3'b000;
      m_fall = 3'b000;
      if (rst) begin
         m_s1 = 3'b000; m_sync = 3'b000; m_clean = 3'b000; m_busy = 3'b000;
         for (int c = 0; c < NCH; c++) m_dis[c] = 0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (m_sync[c] != m_clean[c]) begin
               if (m_dis[c] == STABLE - 1) begin
                  m_dis[c]   = 0;
                  m_clean[c] = ~m_clean[c];
                  if (m_clean[c]) m_rise[c] = 1'b1;
                  else            m_fall[c] = 1'b1;
               end else begin
                  m_dis[c]++;
               end
            end else begin
               m_dis[c] = 0;
            end
            m_busy[c] = (m_dis[c] != 0);
         end
         m_sync = m_s1;
         m_s1   = raw_in;
      end
      e.clean = m_clean; e.rise = m_rise; e.fall = m_fall; e.busy = m_busy;
      q.push_back(e);
   endtask

   task automatic check_out(input string tag);
      exp_t e;
      e = q.pop_front();
      check({tag, ".clean"}, clean_out,  e.clean);
      check({tag, ".rise"},  rise_pulse, e.rise);
      check({tag, ".fall"},  fall_pulse, e.fall);
      check({tag, ".busy"},  busy,       e.busy);
   endtask

   // drive raw, clock once, then compare against the scoreboard head
   task automatic tick(input logic [NCH-1:0] r, input string tag);
      raw_in = r;
      @(posedge clk);
      model_step();
      #1;
      check_out(tag);
      for (int c = 0; c < NCH; c++) begin
         if (rise_pulse[c] === 1'b1) n_rise[c]++;
         if (fall_pulse[c] === 1'b1) n_fall[c]++;
      end
   endtask

   task automatic clear_counts();
      for (int c = 0; c < NCH; c++) begin
         n_rise[c] = 0;
         n_fall[c] = 0;
      end
   endtask

   // asynchronous reset assertion mid-cycle; outputs must clear without a clock
   task automatic apply_rst(input string tag);
      rst = 1'b1;
      model_step();
      #1;
      check_out(tag);
   endtask

   initial begin
      rst    = 1'b1;
      raw_in = 3'b000;
      m_s1 = 3'b000; m_sync = 3'b000; m_clean = 3'b000;
      m_rise = 3'b000; m_fall = 3'b000; m_busy = 3'b000;
      for (int c = 0; c < NCH; c++) m_dis[c] = 0;
      clear_counts();

      // reset with raw held high
      for (int i = 0; i < 3; i++) tick(3'b111, "rst_hold");
      check("rst_hold_clean", clean_out, 3'b000);
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) tick(3'b111, "rst_rel");
      check("rst_rel_pre6", clean_out, 3'b000);
      tick(3'b111, "rst_rel_e6");
      check("rst_rel_clean6", clean_out, 3'b111);
      check("rst_rel_rise6", rise_pulse, 3'b111);
      tick(3'b111, "rst_rel_e7");
      check("rst_rel_rise7", rise_pulse, 3'b000);

      // all channels back low
      for (int i = 1; i <= 5; i++) tick(3'b000, "all_fall");
      tick(3'b000, "all_fall_e6");
      check("all_fall6", fall_pulse, 3'b111);
      for (int i = 0; i < 2; i++) tick(3'b000, "idle");

      // clean step on channel 0
      tick(3'b001, "step_e1");
      tick(3'b001, "step_e2");
      check("step_busy2", busy, 3'b000);
      tick(3'b001, "step_e3");
      check("step_busy3", busy, 3'b001);
      tick(3'b001, "step_e4");
      tick(3'b001, "step_e5");
      tick(3'b001, "step_e6");
      check("step_clean6", clean_out, 3'b001);
      check("step_rise6", rise_pulse, 3'b001);
      tick(3'b001, "step_e7");
      check("step_rise7", rise_pulse, 3'b000);

      // glitch on channel 1: three cycles high is one too short
      clear_counts();
      for (int i = 0; i < 3; i++) tick(3'b011, "glitch_hi");
      for (int i = 0; i < 6; i++) tick(3'b001, "glitch_lo");
      check("glitch_clean", clean_out, 3'b001);
      check("glitch_busy", busy, 3'b000);
      check("glitch_strobes", 3'(n_rise[1] + n_fall[1]), 3'd0);

      // bounce on channel 2, then hold high
      clear_counts();
      tick(3'b101, "bounce_t1");
      tick(3'b001, "bounce_t2");
      tick(3'b101, "bounce_t3");
      tick(3'b001, "bounce_t4");
      tick(3'b101, "bounce_t5");
      for (int i = 6; i <= 9; i++) tick(3'b101, "bounce_hold");
      check("bounce_pre_rise", 3'(n_rise[2]), 3'd0);
      tick(3'b101, "bounce_t10");
      check("bounce_rise10", rise_pulse, 3'b100);
      for (int i = 0; i < 4; i++) tick(3'b101, "bounce_after");
      check("bounce_rise_count", 3'(n_rise[2]), 3'd1);
      for (int i = 1; i <= 5; i++) tick(3'b001, "ch2_fall");
      tick(3'b001, "ch2_fall_e6");
      check("ch2_fall6", fall_pulse, 3'b100);
      for (int i = 0; i < 3; i++) tick(3'b001, "ch2_after");
      check("ch2_fall_count", 3'(n_fall[2]), 3'd1);

      // reset in the middle of a candidate rise
      for (int i = 0; i < 8; i++) tick(3'b000, "settle");
      clear_counts();
      for (int i = 0; i < 3; i++) tick(3'b001, "midrst_cnt");
      check("midrst_busy", busy, 3'b001);
      apply_rst("midrst_async");
      tick(3'b001, "midrst_hold");
      rst = 1'b0;
      for (int i = 1; i <= 5; i++) tick(3'b001, "midrst_rel");
      check("midrst_pre6", clean_out, 3'b000);
      check("midrst_no_strobe", 3'(n_rise[0] + n_fall[0]), 3'd0);
      tick(3'b001, "midrst_e6");
      check("midrst_clean6", clean_out, 3'b001);
      check("midrst_rise6", rise_pulse, 3'b001);

      // simultaneous rise on channels 0 and 2
      for (int i = 0; i < 8; i++) tick(3'b000, "settle2");
      for (int i = 1; i <= 5; i++) tick(3'b101, "simul");
      tick(3'b101, "simul_e6");
      check("simul_rise6", rise_pulse, 3'b101);
      check("simul_fall6", fall_pulse, 3'b000);
      tick(3'b101, "simul_e7");
      check("simul_rise7", rise_pulse, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
